vc_credit_split: RTL

Per-router credit tracker for the VC-based mesh. It holds one credit counter per (output port, VC) pair. It takes merged per-output-port credit-return and consume vectors, in the same field layout the switch-side OR-merge produces. It then splits availability back into one compressed vector per input port, with each port's own field removed. It sits between the downstream credit-return links and the VC allocator.

---
 rtl/vc_credit_split_if.sv | 29 ++
 rtl/vc_credit_split.sv | 97 +++++++++
 2 files changed

// File: rtl/vc_credit_split_if.sv
// Credit tracker bus: merged credit/consume inputs, split availability and error outputs.
interface vc_credit_split_if #(
  parameter int unsigned OUT_WIDTH      = 20,
  parameter int unsigned IN_ARRAY_WIDTH = 80
);
  logic [OUT_WIDTH-1:0]      credit_in;
  logic [OUT_WIDTH-1:0]      consume_in;
  logic [IN_ARRAY_WIDTH-1:0] avail_out;
  logic                      err_overflow;
  logic                      err_underflow;

  // Credit-return / flit-send side that drives events and observes availability
  modport master (
    output credit_in,
    output consume_in,
    input  avail_out,
    input  err_overflow,
    input  err_underflow
  );

  // Credit tracker side
  modport slave (
    input  credit_in,
    input  consume_in,
    output avail_out,
    output err_overflow,
    output err_underflow
  );
endinterface

// File: rtl/vc_credit_split.sv
// Per-router credit tracker: one saturating counter per (output port, VC),
// availability split into per-input-port vectors with the port's own field removed.
module vc_credit_split #(
  parameter int unsigned IN_ARRAY_WIDTH = 80,
  parameter int unsigned IN_NUM         = 5,
  parameter int unsigned BUF_DEPTH      = 4,
  parameter int unsigned CNT_W          = 3
) (
  input logic              clk,
  input logic              reset,
  vc_credit_split_if.slave bus
);

  localparam int unsigned IN_WIDTH  = IN_ARRAY_WIDTH / IN_NUM;
  localparam int unsigned CMP_VAL   = IN_WIDTH / (IN_NUM - 1);
  localparam int unsigned OUT_WIDTH = IN_WIDTH + CMP_VAL;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(BUF_DEPTH);

  logic [OUT_WIDTH-1:0]      ovf_hit;
  logic [OUT_WIDTH-1:0]      unf_hit;
  logic [OUT_WIDTH-1:0]      avail_d;
  logic [IN_ARRAY_WIDTH-1:0] avail_out_d;
  logic [IN_ARRAY_WIDTH-1:0] avail_out_q;
  logic                      err_overflow_q;
  logic                      err_overflow_d;
  logic                      err_underflow_q;
  logic                      err_underflow_d;

  for (genvar i = 0; i < OUT_WIDTH; i++) begin : g_cnt
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             ovf_c;
    logic             unf_c;

    // Saturating counter update; simultaneous credit and consume cancel out
    always_comb begin
      cnt_d = cnt_q;
      ovf_c = 1'b0;
      unf_c = 1'b0;
      case ({bus.credit_in[i], bus.consume_in[i]})
        2'b10: begin
          if (cnt_q == FULL) ovf_c = 1'b1;
          else               cnt_d = cnt_q + CNT_W'(1);
        end
        2'b01: begin
          if (cnt_q == '0) unf_c = 1'b1;
          else             cnt_d = cnt_q - CNT_W'(1);
        end
        default: cnt_d = cnt_q;
      endcase
    end

    // Counter register; reset restores a full set of credits
    always_ff @(posedge clk) begin
      if (reset) cnt_q <= FULL;
      else       cnt_q <= cnt_d;
    end

    assign ovf_hit[i] = ovf_c;
    assign unf_hit[i] = unf_c;
    // Availability is taken from the next count so the registered view
    // tracks the counter register with no extra cycle of delay.
    assign avail_d[i] = (cnt_d != '0);
  end

  // Split: port j sees fields below its own unchanged, fields above shifted down by one
  for (genvar j = 0; j < IN_NUM; j++) begin : g_port
    for (genvar k = 0; k < IN_WIDTH; k++) begin : g_bit
      if (k < CMP_VAL * j) begin : g_lo
        assign avail_out_d[IN_WIDTH*j+k] = avail_d[k];
      end else begin : g_hi
        assign avail_out_d[IN_WIDTH*j+k] = avail_d[k+CMP_VAL];
      end
    end
  end

  assign err_overflow_d  = err_overflow_q  | (|ovf_hit);
  assign err_underflow_d = err_underflow_q | (|unf_hit);

  // Output registers and sticky error flags; reset discards same-cycle events
  always_ff @(posedge clk) begin
    if (reset) begin
      avail_out_q     <= '1;
      err_overflow_q  <= 1'b0;
      err_underflow_q <= 1'b0;
    end else begin
      avail_out_q     <= avail_out_d;
      err_overflow_q  <= err_overflow_d;
      err_underflow_q <= err_underflow_d;
    end
  end

  assign bus.avail_out     = avail_out_q;
  assign bus.err_overflow  = err_overflow_q;
  assign bus.err_underflow = err_underflow_q;

endmodule
